motor_pwm_driver: RTL and testbench

Downstream stage of the line-follow steering block. It consumes the per-motor direction pairs and enables that the steering block produces, and drives the two H-bridge channels. Each channel gets PWM speed control, a soft-start ramp, and a mandatory dead-time coast whenever direction reverses or the motor stops. This keeps the bridge from seeing instant forward/backward flips such as 4'b0110 to 4'b1010.

---
 rtl/motor_pkg.sv | 18 +
 rtl/motor_pwm_channel.sv | 94 +++++++++
 rtl/motor_pwm_driver.sv | 93 +++++++++
 tb/tb_motor_pwm_driver.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// rtl/motor_pkg.sv - shared types, constants and helpers for the motor PWM driver
package motor_pkg;

  typedef enum logic [1:0] {
    STOP,
    RUN,
    DEAD
  } chan_state_t;

  localparam logic [1:0] DIR_A     = 2'b01;
  localparam logic [1:0] DIR_B     = 2'b10;
  localparam logic [7:0] DUTY_FULL = 8'hFF;

  function automatic logic is_valid_dir(input logic [1:0] pair);
    return (pair == DIR_A) || (pair == DIR_B);
  endfunction

endpackage

// File: rtl/motor_pwm_channel.sv
// rtl/motor_pwm_channel.sv - one H-bridge channel: STOP/RUN/DEAD control, soft-start ramp, PWM compare
module motor_pwm_channel
  import motor_pkg::*;
#(
  parameter int RAMP_STEP   = 16,
  parameter int DEAD_CYCLES = 50000,
  parameter int DEAD_W      = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pwm_cnt,
  input  logic       period_start,
  input  logic [1:0] cmd_pair,
  input  logic       cmd_en,
  input  logic [7:0] duty,
  output logic [1:0] pair_nxt,
  output logic       en_nxt,
  output logic       dead_nxt
);

  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);

  chan_state_t       state, state_n;
  logic [1:0]        dir, dir_n;
  logic [7:0]        duty_cur, duty_n;
  logic [DEAD_W-1:0] dead_cnt, dead_cnt_n;
  logic              cmd_valid;
  logic [8:0]        ramp_sum;

  assign cmd_valid = cmd_en && is_valid_dir(cmd_pair);
  assign ramp_sum  = {1'b0, duty_cur} + 9'(RAMP_STEP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= STOP;
      dir      <= 2'b00;
      duty_cur <= 8'd0;
      dead_cnt <= '0;
    end else begin
      state    <= state_n;
      dir      <= dir_n;
      duty_cur <= duty_n;
      dead_cnt <= dead_cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    dir_n      = dir;
    duty_n     = duty_cur;
    dead_cnt_n = dead_cnt;
    unique case (state)
      STOP: begin
        duty_n = 8'd0;
        if (cmd_valid) begin
          state_n = RUN;
          dir_n   = cmd_pair;
        end
      end
      RUN: begin
        if (!cmd_valid || (cmd_pair != dir)) begin
          state_n    = DEAD;
          dead_cnt_n = '0;
          duty_n     = 8'd0;
        end else if (duty_cur > duty) begin
          duty_n = duty;
        end else if (period_start && (duty_cur < duty)) begin
          duty_n = (ramp_sum > {1'b0, duty}) ? duty : ramp_sum[7:0];
        end
      end
      DEAD: begin
        duty_n = 8'd0;
        // The command is looked at only on the exit clock.
        if (dead_cnt == DEAD_LAST) begin
          if (cmd_valid) begin
            state_n = RUN;
            dir_n   = cmd_pair;
          end else begin
            state_n = STOP;
          end
        end else begin
          dead_cnt_n = dead_cnt + 1'b1;
        end
      end
      default: state_n = STOP;
    endcase

    // Outputs reflect the state being entered so the top can register them on the same edge.
    pair_nxt = (state_n == RUN) ? dir_n : 2'b00;
    en_nxt   = (state_n == RUN) && ((duty_n == DUTY_FULL) || (pwm_cnt < duty_n));
    dead_nxt = (state_n == DEAD);
  end

endmodule

// File: rtl/motor_pwm_driver.sv
// rtl/motor_pwm_driver.sv - dual H-bridge driver: input/output registers, shared PWM timebase, two channels
module motor_pwm_driver
  import motor_pkg::*;
#(
  parameter int PRESC_DIV   = 4,
  parameter int RAMP_STEP   = 16,
  parameter int DEAD_CYCLES = 50000,
  parameter int DEAD_W      = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] motor_in,
  input  logic [1:0] motor_en,
  input  logic [7:0] duty,
  output logic [3:0] hb_in,
  output logic [1:0] hb_en,
  output logic [1:0] dead_active
);

  localparam int PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;

  logic [3:0]    motor_r;
  logic [1:0]    en_r;
  logic [7:0]    duty_r;
  logic [PW-1:0] presc, presc_n;
  logic [7:0]    pwm_cnt, pwm_cnt_n;
  logic          tick, period_start;
  logic [1:0]    l_pair, r_pair;
  logic          l_en, r_en, l_dead, r_dead;

  assign tick         = (presc == PW'(PRESC_DIV - 1));
  assign presc_n      = tick ? '0 : presc + 1'b1;
  assign pwm_cnt_n    = tick ? pwm_cnt + 8'd1 : pwm_cnt;
  assign period_start = tick && (pwm_cnt == 8'hFF);

  always_ff @(posedge clk) begin
    if (reset) begin
      motor_r     <= 4'd0;
      en_r        <= 2'd0;
      duty_r      <= 8'd0;
      presc       <= '0;
      pwm_cnt     <= 8'd0;
      hb_in       <= 4'd0;
      hb_en       <= 2'd0;
      dead_active <= 2'd0;
    end else begin
      motor_r     <= motor_in;
      en_r        <= motor_en;
      duty_r      <= duty;
      presc       <= presc_n;
      pwm_cnt     <= pwm_cnt_n;
      hb_in       <= {l_pair, r_pair};
      hb_en       <= {l_en, r_en};
      dead_active <= {l_dead, r_dead};
    end
  end

  // Channels see the counter value being loaded on this edge, matching the registered outputs.
  motor_pwm_channel #(
    .RAMP_STEP  (RAMP_STEP),
    .DEAD_CYCLES(DEAD_CYCLES),
    .DEAD_W     (DEAD_W)
  ) u_left (
    .clk         (clk),
    .reset       (reset),
    .pwm_cnt     (pwm_cnt_n),
    .period_start(period_start),
    .cmd_pair    (motor_r[3:2]),
    .cmd_en      (en_r[1]),
    .duty        (duty_r),
    .pair_nxt    (l_pair),
    .en_nxt      (l_en),
    .dead_nxt    (l_dead)
  );

  motor_pwm_channel #(
    .RAMP_STEP  (RAMP_STEP),
    .DEAD_CYCLES(DEAD_CYCLES),
    .DEAD_W     (DEAD_W)
  ) u_right (
    .clk         (clk),
    .reset       (reset),
    .pwm_cnt     (pwm_cnt_n),
    .period_start(period_start),
    .cmd_pair    (motor_r[1:0]),
    .cmd_en      (en_r[0]),
    .duty        (duty_r),
    .pair_nxt    (r_pair),
    .en_nxt      (r_en),
    .dead_nxt    (r_dead)
  );

endmodule

// File: tb/tb_motor_pwm_driver.sv
// tb/tb_motor_pwm_driver.sv - directed self-checking bench for motor_pwm_driver
module tb_motor_pwm_driver;

  logic       clk;
  logic       reset;
  logic [3:0] motor_in;
  logic [1:0] motor_en;
  logic [7:0] duty;
  logic [3:0] hb_in;
  logic [1:0] hb_en;
  logic [1:0] dead_active;

  int         n_cmp;
  int         n_bad;
  logic [7:0] pc;

  motor_pwm_driver #(
    .PRESC_DIV  (1),
    .RAMP_STEP  (64),
    .DEAD_CYCLES(8),
    .DEAD_W     (16)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .motor_in   (motor_in),
    .motor_en   (motor_en),
    .duty       (duty),
    .hb_in      (hb_in),
    .hb_en      (hb_en),
    .dead_active(dead_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // pc mirrors the expected pwm_cnt (PRESC_DIV=1: +1 per clock, 0 under reset).
  task automatic step();
    @(posedge clk);
    if (reset) pc = 8'd0;
    else pc = pc + 8'd1;
    #1;
  endtask

  task automatic wait_pc(input logic [7:0] v);
    while (pc != v) step();
  endtask

  task automatic next_period();
    do step(); while (pc != 8'd0);
  endtask

  task automatic measure(output int l, output int r);
    l = 0;
    r = 0;
    repeat (256) begin
      l += int'(hb_en[1]);
      r += int'(hb_en[0]);
      step();
    end
  endtask

  initial begin
    int l_hi, r_hi, nd, nr, np;
    n_cmp = 0;
    n_bad = 0;
    pc = 8'd0;
    reset = 1'b1;
    motor_in = 4'b0000;
    motor_en = 2'b00;
    duty = 8'd0;
    step();
    step();
    chk("reset_hb_in", 32'(hb_in), 32'h0);
    chk("reset_hb_en", 32'(hb_en), 32'h0);
    chk("reset_dead", 32'(dead_active), 32'h0);

    // Forward run, ramp 64/128/192/200
    reset = 1'b0;
    motor_in = 4'b0101;
    motor_en = 2'b11;
    duty = 8'd200;
    step();
    chk("latency_clk1_hb_in", 32'(hb_in), 32'h0);
    step();
    chk("latency_clk2_hb_in", 32'(hb_in), 32'h5);
    chk("start_hb_en", 32'(hb_en), 32'h0);
    next_period();
    chk("ramp_64", 32'(u_dut.u_left.duty_cur), 32'd64);
    next_period();
    chk("ramp_128", 32'(u_dut.u_left.duty_cur), 32'd128);
    next_period();
    chk("ramp_192", 32'(u_dut.u_right.duty_cur), 32'd192);
    next_period();
    chk("ramp_200", 32'(u_dut.u_right.duty_cur), 32'd200);
    measure(l_hi, r_hi);
    chk("pwm200_left_high", 32'(l_hi), 32'd200);
    chk("pwm200_right_high", 32'(r_hi), 32'd200);

    // Both reverse: 8 clocks of coast, then ramp restarts
    motor_in = 4'b1010;
    step();
    chk("rev_before_dead_hb_in", 32'(hb_in), 32'h5);
    step();
    nd = 0;
    repeat (12) begin
      if (dead_active == 2'b11 && hb_in == 4'b0000 && hb_en == 2'b00) nd++;
      step();
    end
    chk("rev_dead_clocks", 32'(nd), 32'd8);
    chk("rev_after_hb_in", 32'(hb_in), 32'hA);
    chk("rev_after_dead", 32'(dead_active), 32'h0);
    chk("rev_ramp_restart", 32'(u_dut.u_left.duty_cur), 32'd0);

    // Full duty saturates at 255, then immediate drop to 50
    duty = 8'd255;
    next_period();
    next_period();
    next_period();
    next_period();
    chk("ramp_sat_255", 32'(u_dut.u_left.duty_cur), 32'd255);
    measure(l_hi, r_hi);
    chk("full_left_high", 32'(l_hi), 32'd256);
    chk("full_right_high", 32'(r_hi), 32'd256);
    duty = 8'd50;
    step();
    chk("drop_not_yet", 32'(u_dut.u_left.duty_cur), 32'd255);
    step();
    chk("drop_to_50", 32'(u_dut.u_left.duty_cur), 32'd50);
    chk("drop_en_pc2", 32'(hb_en), 32'h3);
    wait_pc(8'd49);
    chk("pwm50_en_pc49", 32'(hb_en), 32'h3);
    step();
    chk("pwm50_en_pc50", 32'(hb_en), 32'h0);

    // Left only reverses (1010 -> 0110) across the period wrap
    wait_pc(8'd250);
    motor_in = 4'b0110;
    step();
    step();
    nd = 0;
    nr = 0;
    np = 0;
    repeat (12) begin
      if (dead_active == 2'b10 && hb_in[3:2] == 2'b00) nd++;
      nr += int'(hb_en[0]);
      if (hb_in[1:0] == 2'b10) np++;
      step();
    end
    chk("left_dead_clocks", 32'(nd), 32'd8);
    chk("right_pwm_kept", 32'(nr), 32'd8);
    chk("right_pair_kept", 32'(np), 32'd12);
    chk("left_rev_hb_in", 32'(hb_in), 32'h6);
    chk("left_rev_hb_en", 32'(hb_en), 32'h1);

    // Right only reverses (0110 -> 0101)
    motor_in = 4'b0101;
    step();
    step();
    nd = 0;
    np = 0;
    repeat (12) begin
      if (dead_active == 2'b01 && hb_in[1:0] == 2'b00) nd++;
      if (hb_in[3:2] == 2'b01) np++;
      step();
    end
    chk("right_dead_clocks", 32'(nd), 32'd8);
    chk("left_pair_kept", 32'(np), 32'd12);
    chk("right_rev_hb_in", 32'(hb_in), 32'h5);

    // Commands toggled during DEAD, final stop -> STOP
    motor_in = 4'b1010;
    step();
    step();
    chk("tog1_dead", 32'(dead_active), 32'h3);
    step();
    motor_in = 4'b0101;
    step();
    step();
    motor_in = 4'b0000;
    wait_pc(8'd31);
    chk("tog1_last_dead", 32'(dead_active), 32'h3);
    step();
    chk("tog1_exit_hb_in", 32'(hb_in), 32'h0);
    chk("tog1_exit_dead", 32'(dead_active), 32'h0);
    wait_pc(8'd40);
    chk("tog1_stays_stop", 32'({dead_active, hb_en, hb_in}), 32'h0);

    // Same again, final command 1010 -> RUN with dir 1010
    motor_in = 4'b0101;
    step();
    step();
    chk("tog2_run_hb_in", 32'(hb_in), 32'h5);
    wait_pc(8'd44);
    motor_in = 4'b1010;
    wait_pc(8'd47);
    motor_in = 4'b0101;
    wait_pc(8'd49);
    motor_in = 4'b0000;
    wait_pc(8'd51);
    motor_in = 4'b1010;
    wait_pc(8'd53);
    chk("tog2_last_dead", 32'(dead_active), 32'h3);
    step();
    chk("tog2_exit_hb_in", 32'(hb_in), 32'hA);
    chk("tog2_exit_dead", 32'(dead_active), 32'h0);

    // Reset mid-DEAD (left) and mid-ramp (right)
    duty = 8'd200;
    next_period();
    chk("pre_reset_ramp", 32'(u_dut.u_right.duty_cur), 32'd64);
    motor_in = 4'b0110;
    step();
    step();
    chk("pre_reset_dead", 32'(dead_active), 32'h2);
    step();
    step();
    reset = 1'b1;
    step();
    chk("rst_hb_in", 32'(hb_in), 32'h0);
    chk("rst_hb_en", 32'(hb_en), 32'h0);
    chk("rst_dead", 32'(dead_active), 32'h0);
    chk("rst_duty_cur", 32'(u_dut.u_right.duty_cur), 32'd0);
    reset = 1'b0;
    step();
    chk("post_rst_clk1_hb_in", 32'(hb_in), 32'h0);
    step();
    chk("post_rst_clk2_hb_in", 32'(hb_in), 32'h6);
    chk("post_rst_no_dead", 32'(dead_active), 32'h0);
    next_period();
    chk("post_rst_ramp_l", 32'(u_dut.u_left.duty_cur), 32'd64);
    chk("post_rst_ramp_r", 32'(u_dut.u_right.duty_cur), 32'd64);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
